// File: rtl/imem_axi_rd_responder.sv
// AXI4 read responder over a preloadable word-addressed instruction memory; first RVALID LATENCY cycles after AR, then one beat per cycle.
// Backpressure: a beat is held stable while RREADY is low; ARREADY only in IDLE. Define IMEM_WRAP_BURST_EN for WRAP bursts.
module imem_axi_rd_responder #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int LEN_W   = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [ADDR_W-1:0]        ARADDR,
    input  logic [LEN_W-1:0]         ARLEN,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY,
    input  logic                     mem_we,
    input  logic [$clog2(DEPTH)-1:0] mem_waddr,
    input  logic [31:0]              mem_wdata
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  beats_left;
    logic [3:0]        lat_cnt;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] beat_addr;
    logic [LEN_W-1:0]  beat_bl;
    logic              advance;
    logic              load;
    logic              beat_oor;
    logic [31:0]       beat_word;

`ifdef IMEM_WRAP_BURST_EN
    logic [ADDR_W-1:0] wrap_mask;

    // Critical-word-first: only the offset bits inside the aligned block advance.
    always_comb begin
        next_addr = (addr & ~wrap_mask) | ((addr + ADDR_W'(4)) & wrap_mask);
    end
`else
    always_comb begin
        next_addr = addr + ADDR_W'(4);
    end
`endif

    // The next beat is fetched on the same edge the current one is accepted.
    assign advance   = (state == BURST) && RVALID && RREADY && !RLAST;
    assign load      = ((state == WAIT) && (lat_cnt == 4'd0)) ||
                       ((state == BURST) && !RVALID) || advance;
    assign beat_addr = advance ? next_addr : addr;
    assign beat_bl   = advance ? beats_left - LEN_W'(1) : beats_left;
    assign beat_oor  = {1'b0, beat_addr} >= (ADDR_W+1)'(DEPTH * 4);
    assign beat_word = mem[beat_addr[AW+1:2]];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            addr       <= '0;
            beats_left <= '0;
            lat_cnt    <= '0;
            ARREADY    <= 1'b0;
            RVALID     <= 1'b0;
            RLAST      <= 1'b0;
            RDATA      <= '0;
            RRESP      <= 2'b00;
`ifdef IMEM_WRAP_BURST_EN
            wrap_mask  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!ARREADY) begin
                        ARREADY <= 1'b1;
                    end else if (ARVALID) begin
                        addr       <= ARADDR;
                        beats_left <= ARLEN;
                        lat_cnt    <= 4'(LATENCY - 1);
                        ARREADY    <= 1'b0;
`ifdef IMEM_WRAP_BURST_EN
                        wrap_mask  <= ADDR_W'({ARLEN, 2'b11});
`endif
                        state      <= (LATENCY == 1) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (RVALID && RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            addr       <= next_addr;
                            beats_left <= beats_left - LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                RVALID <= 1'b1;
                RDATA  <= beat_oor ? 32'h0 : beat_word;
                RRESP  <= beat_oor ? 2'b10 : 2'b00;
                RLAST  <= (beat_bl == '0);
            end
        end
    end
endmodule

// File: tb/tb_imem_axi_rd_responder.sv
// Scoreboard bench for imem_axi_rd_responder: expected beats are queued at AR issue and compared as R handshakes occur.
module tb_imem_axi_rd_responder;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int LEN_W   = 4;
    localparam int AW      = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              resetn;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [31:0]       mem_wdata;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       exp_b;
    logic [31:0] model [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    imem_axi_rd_responder #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic beat_t exp_beat(input logic [31:0] a, input logic last);
        if (a >= 32'(DEPTH * 4)) return beat_t'({32'h0, 2'b10, last});
        return beat_t'({model[a[AW+1:2]], 2'b00, last});
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        mem_we    = 1'b1;
        mem_waddr = AW'(idx);
        mem_wdata = d;
        model[idx] = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    // Waits (bounded) for ARREADY, presents one AR for a single edge, returns at the following negedge.
    task automatic issue_ar(input logic [31:0] a, input logic [LEN_W-1:0] len);
        for (int k = 0; k < 50 && !ARREADY; k++) @(negedge clk);
        ARADDR  = a;
        ARLEN   = len;
        ARVALID = 1'b1;
        @(negedge clk);
        ARVALID = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        #22;
        n_checks++;
        if ({ARREADY, RVALID, RLAST, RDATA, RRESP} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ARREADY=%b RVALID=%b RLAST=%b RDATA=%h RRESP=%b, want all 0",
                     ARREADY, RVALID, RLAST, RDATA, RRESP);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_checks++;
        if (ARREADY !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_arready: got %b, want 0", ARREADY);
        end
        @(negedge clk);
        n_checks++;
        if (ARREADY !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_edge_arready: got %b, want 1", ARREADY);
        end
    endtask

    task automatic test_single_beat;
        preload(3, 32'hDEADBEEF);
        RREADY = 1'b1;
        exp_q.push_back(exp_beat(32'h0000000C, 1'b1));
        issue_ar(32'h0000000C, 4'd0);
        n_checks++;
        if (ARREADY !== 1'b0 || RVALID !== 1'b0) begin
            n_fail++; $display("FAIL single_after_hs: got ARREADY=%b RVALID=%b, want 0 0", ARREADY, RVALID);
        end
        @(negedge clk);
        n_checks++;
        if (RVALID !== 1'b0) begin
            n_fail++; $display("FAIL single_latency_early: RVALID got %b at N+1, want 0", RVALID);
        end
        @(negedge clk);
        exp_b = exp_q.pop_front();
        n_checks++;
        if (RVALID !== 1'b1 || {RDATA, RRESP, RLAST} !== exp_b) begin
            n_fail++;
            $display("FAIL single_beat: got v=%b d=%h r=%b l=%b, want v=1 d=%h r=%b l=%b",
                     RVALID, RDATA, RRESP, RLAST, exp_b.data, exp_b.resp, exp_b.last);
        end
        @(negedge clk);
        n_checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            n_fail++; $display("FAIL single_done: got ARREADY=%b RVALID=%b, want 1 0", ARREADY, RVALID);
        end
    endtask

    task automatic test_refill8;
        logic [34:0] held;
        logic        held_vld;
        logic        tog;
        int          got;
        for (int i = 16; i < 24; i++) preload(i, 32'(i));
        for (int b = 0; b < 8; b++) exp_q.push_back(exp_beat(32'h40 + 32'(4 * b), b == 7));
        RREADY = 1'b0;
        issue_ar(32'h40, 4'd7);
        got = 0; held_vld = 1'b0; tog = 1'b1; held = '0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            if (held_vld) begin
                n_checks++;
                if (RVALID !== 1'b1 || {RDATA, RRESP, RLAST} !== held) begin
                    n_fail++;
                    $display("FAIL refill_hold: got v=%b %h/%b/%b, want v=1 %h", RVALID, RDATA, RRESP, RLAST, held);
                end
            end
            if (RVALID) begin
                if (tog) begin
                    RREADY = 1'b1;
                    exp_b = exp_q.pop_front();
                    n_checks++;
                    if ({RDATA, RRESP, RLAST} !== exp_b) begin
                        n_fail++;
                        $display("FAIL refill_beat%0d: got d=%h r=%b l=%b, want d=%h r=%b l=%b",
                                 got, RDATA, RRESP, RLAST, exp_b.data, exp_b.resp, exp_b.last);
                    end
                    got++;
                    held_vld = 1'b0;
                end else begin
                    RREADY   = 1'b0;
                    held     = {RDATA, RRESP, RLAST};
                    held_vld = 1'b1;
                end
                tog = ~tog;
            end else begin
                RREADY = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 8) begin
            n_fail++; $display("FAIL refill_count: got %0d beats, want 8", got);
        end
        RREADY = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int   got;
        logic last_seen;
        logic drop_arv;
        preload(0, 32'hA0A0_0000);
        preload(1, 32'hB1B1_1111);
        RREADY = 1'b1;
        for (int k = 0; k < 50 && !ARREADY; k++) @(negedge clk);
        exp_q.push_back(exp_beat(32'h0, 1'b1));
        exp_q.push_back(exp_beat(32'h4, 1'b1));
        ARADDR = 32'h0; ARLEN = 4'd0; ARVALID = 1'b1;
        @(negedge clk);
        ARADDR = 32'h4;
        got = 0; last_seen = 1'b0; drop_arv = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 2; cyc++) begin
            if (drop_arv) begin
                ARVALID  = 1'b0;
                drop_arv = 1'b0;
            end
            if (last_seen) begin
                n_checks++;
                if (ARREADY !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_arready: got %b one cycle after RLAST, want 1", ARREADY);
                end
                last_seen = 1'b0;
                drop_arv  = 1'b1;
            end
            if (RVALID) begin
                exp_b = exp_q.pop_front();
                n_checks++;
                if ({RDATA, RRESP, RLAST} !== exp_b) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got d=%h r=%b l=%b, want d=%h r=%b l=%b",
                             got, RDATA, RRESP, RLAST, exp_b.data, exp_b.resp, exp_b.last);
                end
                got++;
                if (got == 1) last_seen = 1'b1;
            end
            @(negedge clk);
        end
        ARVALID = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (RVALID !== 1'b0) begin
                n_fail++; $display("FAIL b2b_extra_beat: RVALID got %b after both bursts, want 0", RVALID);
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 2 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d beats, %0d pending, want 2 and 0", got, exp_q.size());
        end
    endtask

    task automatic test_out_of_range;
        int got;
        preload(1023, 32'h1234_5678);
        RREADY = 1'b1;
        exp_q.push_back(exp_beat(32'h0000_0FFC, 1'b0));
        exp_q.push_back(beat_t'({32'h0, 2'b10, 1'b1}));
        issue_ar(32'h0000_0FFC, 4'd1);
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
            if (RVALID) begin
                exp_b = exp_q.pop_front();
                n_checks++;
                if ({RDATA, RRESP, RLAST} !== exp_b) begin
                    n_fail++;
                    $display("FAIL oor_beat%0d: got d=%h r=%b l=%b, want d=%h r=%b l=%b",
                             got, RDATA, RRESP, RLAST, exp_b.data, exp_b.resp, exp_b.last);
                end
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 2) begin
            n_fail++; $display("FAIL oor_count: got %0d beats, want 2", got);
        end
    endtask

    task automatic test_reset_mid_burst;
        int got;
        RREADY = 1'b1;
        for (int b = 0; b < 8; b++) exp_q.push_back(exp_beat(32'h40 + 32'(4 * b), b == 7));
        issue_ar(32'h40, 4'd7);
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            if (RVALID) begin
                exp_b = exp_q.pop_front();
                n_checks++;
                if ({RDATA, RRESP, RLAST} !== exp_b) begin
                    n_fail++;
                    $display("FAIL rst_mid_beat%0d: got d=%h, want d=%h", got, RDATA, exp_b.data);
                end
                got++;
            end
            @(negedge clk);
        end
        RREADY = 1'b0;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({RVALID, RLAST, ARREADY} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_async: got RVALID=%b RLAST=%b ARREADY=%b, want 0 0 0", RVALID, RLAST, ARREADY);
        end
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ARREADY !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_arready: got %b one edge after release, want 1", ARREADY);
        end
        RREADY = 1'b1;
        exp_q.push_back(exp_beat(32'h40, 1'b1));
        issue_ar(32'h40, 4'd0);
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 1; cyc++) begin
            if (RVALID) begin
                exp_b = exp_q.pop_front();
                n_checks++;
                if ({RDATA, RRESP, RLAST} !== exp_b) begin
                    n_fail++;
                    $display("FAIL rst_fresh_beat: got d=%h r=%b l=%b, want d=%h r=%b l=%b",
                             RDATA, RRESP, RLAST, exp_b.data, exp_b.resp, exp_b.last);
                end
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 1) begin
            n_fail++; $display("FAIL rst_fresh_count: got %0d beats, want 1", got);
        end
    endtask

`ifdef IMEM_WRAP_BURST_EN
    task automatic test_wrap;
        int order [8] = '{22, 23, 16, 17, 18, 19, 20, 21};
        int got;
        RREADY = 1'b1;
        for (int b = 0; b < 8; b++) exp_q.push_back(exp_beat(32'(order[b] * 4), b == 7));
        issue_ar(32'h58, 4'd7);
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            if (RVALID) begin
                exp_b = exp_q.pop_front();
                n_checks++;
                if ({RDATA, RRESP, RLAST} !== exp_b) begin
                    n_fail++;
                    $display("FAIL wrap_beat%0d: got d=%h r=%b l=%b, want d=%h r=%b l=%b",
                             got, RDATA, RRESP, RLAST, exp_b.data, exp_b.resp, exp_b.last);
                end
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 8) begin
            n_fail++; $display("FAIL wrap_count: got %0d beats, want 8", got);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_refill8();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_burst();
`ifdef IMEM_WRAP_BURST_EN
        test_wrap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
